apb_demux: RTL and testbench



---
 rtl/apb_demux_pkg.sv | 24 ++
 rtl/apb_addr_decoder.sv | 29 ++
 rtl/apb_demux.sv | 193 +++++++++++++++++++
 tb/tb_apb_demux.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_demux_pkg.sv
// apb_demux_pkg: shared FSM state encoding and default address map
// for the APB 1-to-N demultiplexer.
package apb_demux_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  // Default map for four slaves: slave i decodes the 256 MB window at i<<28.
  localparam logic [127:0] DEFAULT_SLAVE_BASE = {
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam logic [127:0] DEFAULT_SLAVE_MASK = {4{32'hF000_0000}};

  // Slave index width; a single-slave build still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: combinational base/mask window match; lowest index
// wins when windows overlap.
module apb_addr_decoder #(
  parameter int                                           NUM_APB_SLAVES = 4,
  parameter int                                           APB_ADDR_WIDTH = 32,
  parameter int                                           IDX_W          = 2,
  parameter logic [NUM_APB_SLAVES*APB_ADDR_WIDTH-1:0]     SLAVE_BASE     = '0,
  parameter logic [NUM_APB_SLAVES*APB_ADDR_WIDTH-1:0]     SLAVE_MASK     = '0
) (
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic                      hit,
  output logic [IDX_W-1:0]          idx
);

  // Scan upward and keep only the first matching window.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_APB_SLAVES; i++) begin
      if (!hit &&
          ((PADDR & SLAVE_MASK[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) ==
           SLAVE_BASE[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_demux.sv
// apb_demux: APB 1-to-N demultiplexer. Captures one upstream transfer,
// replays it as SETUP/ACCESS on the decoded slave and returns a registered
// response; unmapped addresses complete with PSLVERR.
// Optional feature macro: APB_DEMUX_TIMEOUT_EN (downstream access timeout).
module apb_demux
  import apb_demux_pkg::*;
#(
  parameter int                                       NUM_APB_SLAVES = 4,
  parameter int                                       APB_ADDR_WIDTH = 32,
  parameter int                                       APB_DATA_WIDTH = 32,
  parameter int                                       APB_STRB_WIDTH = 4,
  parameter logic [NUM_APB_SLAVES*APB_ADDR_WIDTH-1:0] SLAVE_BASE     = DEFAULT_SLAVE_BASE,
  parameter logic [NUM_APB_SLAVES*APB_ADDR_WIDTH-1:0] SLAVE_MASK     = DEFAULT_SLAVE_MASK,
  parameter int                                       TIMEOUT_CYCLES = 256
) (
  input  logic                                           PCLK,
  input  logic                                           PRESET,
  input  logic                                           PSEL_s,
  input  logic                                           PENABLE_s,
  input  logic                                           PWRITE_s,
  input  logic [APB_ADDR_WIDTH-1:0]                      PADDR_s,
  input  logic [APB_DATA_WIDTH-1:0]                      PWDATA_s,
  input  logic [APB_STRB_WIDTH-1:0]                      PSTRB_s,
  input  logic [2:0]                                     PPROT_s,
  output logic [APB_DATA_WIDTH-1:0]                      PRDATA_s,
  output logic                                           PREADY_s,
  output logic                                           PSLVERR_s,
  output logic [NUM_APB_SLAVES-1:0]                      PSEL_m,
  output logic [NUM_APB_SLAVES-1:0]                      PENABLE_m,
  output logic [NUM_APB_SLAVES-1:0]                      PWRITE_m,
  output logic [NUM_APB_SLAVES-1:0][APB_ADDR_WIDTH-1:0]  PADDR_m,
  output logic [NUM_APB_SLAVES-1:0][APB_DATA_WIDTH-1:0]  PWDATA_m,
  output logic [NUM_APB_SLAVES-1:0][APB_STRB_WIDTH-1:0]  PSTRB_m,
  output logic [NUM_APB_SLAVES-1:0][2:0]                 PPROT_m,
  input  logic [NUM_APB_SLAVES-1:0][APB_DATA_WIDTH-1:0]  PRDATA_m,
  input  logic [NUM_APB_SLAVES-1:0]                      PREADY_m,
  input  logic [NUM_APB_SLAVES-1:0]                      PSLVERR_m
);

  localparam int IDX_W = idx_width(NUM_APB_SLAVES);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_demux: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic [APB_STRB_WIDTH-1:0] strb_q;
  logic [2:0]                prot_q;
  logic [IDX_W-1:0]          idx_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic                      abort_q;

  logic                      dec_hit;
  logic [IDX_W-1:0]          dec_idx;
  logic                      capture;
  logic                      sel_ready;
  logic                      expired;

  apb_addr_decoder #(
    .NUM_APB_SLAVES (NUM_APB_SLAVES),
    .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
    .IDX_W          (IDX_W),
    .SLAVE_BASE     (SLAVE_BASE),
    .SLAVE_MASK     (SLAVE_MASK)
  ) u_decoder (
    .PADDR (PADDR_s),
    .hit   (dec_hit),
    .idx   (dec_idx)
  );

  assign capture   = (state_q == IDLE) && PSEL_s && !PENABLE_s;
  assign sel_ready = PREADY_m[idx_q];

`ifdef APB_DEMUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of access cycles spent waiting on the slave.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else if (state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !sel_ready && cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // This is the last allowed not-ready cycle; a same-cycle PREADY still wins.
  assign expired = (state_q == ACCESS) && !sel_ready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expired = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture on an upstream setup phase seen while idle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      idx_q   <= '0;
    end else if (capture) begin
      addr_q  <= PADDR_s;
      write_q <= PWRITE_s;
      wdata_q <= PWDATA_s;
      strb_q  <= PSTRB_s;
      prot_q  <= PPROT_s;
      idx_q   <= dec_idx;
    end
  end

  // Response registers and upstream-abort tracking.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (capture) begin
        abort_q <= 1'b0;
      end else if ((state_q == SETUP || state_q == ACCESS) && !PSEL_s) begin
        abort_q <= 1'b1;
      end
      if (state_q == ACCESS && sel_ready) begin
        rdata_q <= PRDATA_m[idx_q];
        err_q   <= PSLVERR_m[idx_q];
      end else if (expired) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Next-state decode and output drive from the current state.
  always_comb begin
    state_d   = state_q;
    PRDATA_s  = '0;
    PREADY_s  = 1'b0;
    PSLVERR_s = 1'b0;
    PSEL_m    = '0;
    PENABLE_m = '0;
    PWRITE_m  = '0;
    PADDR_m   = '0;
    PWDATA_m  = '0;
    PSTRB_m   = '0;
    PPROT_m   = '0;
    case (state_q)
      IDLE: begin
        if (capture) state_d = dec_hit ? SETUP : ERR;
      end
      SETUP, ACCESS: begin
        PSEL_m[idx_q]    = 1'b1;
        PENABLE_m[idx_q] = (state_q == ACCESS);
        PWRITE_m[idx_q]  = write_q;
        PADDR_m[idx_q]   = addr_q;
        PWDATA_m[idx_q]  = wdata_q;
        PSTRB_m[idx_q]   = strb_q;
        PPROT_m[idx_q]   = prot_q;
        if (state_q == SETUP)          state_d = ACCESS;
        else if (sel_ready || expired) state_d = DONE;
      end
      DONE: begin
        // An aborted requester is no longer listening; swallow the response.
        if (!abort_q) begin
          PREADY_s  = 1'b1;
          PSLVERR_s = err_q;
          PRDATA_s  = rdata_q;
        end
        state_d = IDLE;
      end
      ERR: begin
        PREADY_s  = 1'b1;
        PSLVERR_s = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_demux.sv
// tb_apb_demux: directed self-checking bench for apb_demux with a
// programmable wait-state slave model on each downstream port.
module tb_apb_demux;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic                    PCLK, PRESET;
  logic                    PSEL_s, PENABLE_s, PWRITE_s;
  logic [AW-1:0]           PADDR_s;
  logic [DW-1:0]           PWDATA_s;
  logic [SW-1:0]           PSTRB_s;
  logic [2:0]              PPROT_s;
  logic [DW-1:0]           PRDATA_s;
  logic                    PREADY_s, PSLVERR_s;
  logic [N-1:0]            PSEL_m, PENABLE_m, PWRITE_m;
  logic [N-1:0][AW-1:0]    PADDR_m;
  logic [N-1:0][DW-1:0]    PWDATA_m;
  logic [N-1:0][SW-1:0]    PSTRB_m;
  logic [N-1:0][2:0]       PPROT_m;
  logic [N-1:0][DW-1:0]    PRDATA_m;
  logic [N-1:0]            PREADY_m, PSLVERR_m;

  logic [N-1:0]            hang;
  int                      waits [N];
  int                      wcnt  [N];

  int n_checks = 0;
  int n_errors = 0;

  apb_demux #(
    .NUM_APB_SLAVES (N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .APB_STRB_WIDTH (SW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PSEL_s    (PSEL_s),
    .PENABLE_s (PENABLE_s),
    .PWRITE_s  (PWRITE_s),
    .PADDR_s   (PADDR_s),
    .PWDATA_s  (PWDATA_s),
    .PSTRB_s   (PSTRB_s),
    .PPROT_s   (PPROT_s),
    .PRDATA_s  (PRDATA_s),
    .PREADY_s  (PREADY_s),
    .PSLVERR_s (PSLVERR_s),
    .PSEL_m    (PSEL_m),
    .PENABLE_m (PENABLE_m),
    .PWRITE_m  (PWRITE_m),
    .PADDR_m   (PADDR_m),
    .PWDATA_m  (PWDATA_m),
    .PSTRB_m   (PSTRB_m),
    .PPROT_m   (PPROT_m),
    .PRDATA_m  (PRDATA_m),
    .PREADY_m  (PREADY_m),
    .PSLVERR_m (PSLVERR_m)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave model: ready after waits[i] not-ready access cycles, never if hung.
  for (genvar g = 0; g < N; g++) begin : g_slave
    assign PREADY_m[g] = PSEL_m[g] & PENABLE_m[g] & ~hang[g] & (wcnt[g] >= waits[g]);
    always @(posedge PCLK) begin
      if (PSEL_m[g] && PENABLE_m[g] && !PREADY_m[g]) wcnt[g] <= wcnt[g] + 1;
      else                                           wcnt[g] <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic any_output();
    return (|PRDATA_s) | PREADY_s | PSLVERR_s | (|PSEL_m) | (|PENABLE_m) |
           (|PWRITE_m) | (|PADDR_m) | (|PWDATA_m) | (|PSTRB_m) | (|PPROT_m);
  endfunction

  // One upstream transfer; called just after a rising edge. Cycle 0 is the
  // upstream setup cycle. Returns at the edge ending the PREADY_s cycle.
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                      output int rdy_cyc, output logic [DW-1:0] rdata, output logic err,
                      output int sel_cyc, output int en_cyc, output int last_sel,
                      output logic [N-1:0] sel_seen, output logic [DW-1:0] wd_seen);
    int cyc = 0;
    rdy_cyc = -1; sel_cyc = -1; en_cyc = -1; last_sel = -1;
    sel_seen = '0; wd_seen = '0; rdata = '0; err = 1'b0;
    PSEL_s = 1'b1; PENABLE_s = 1'b0; PWRITE_s = wr;
    PADDR_s = addr; PWDATA_s = wdata; PSTRB_s = 4'hF; PPROT_s = 3'b010;
    while (rdy_cyc < 0 && cyc < 60) begin
      @(negedge PCLK);
      sel_seen |= PSEL_m;
      if (|PSEL_m) begin
        last_sel = cyc;
        if (sel_cyc < 0) sel_cyc = cyc;
      end
      if (|PENABLE_m && en_cyc < 0) begin
        en_cyc = cyc;
        for (int k = 0; k < N; k++) if (PENABLE_m[k]) wd_seen = PWDATA_m[k];
      end
      if (PREADY_s) begin
        rdy_cyc = cyc; rdata = PRDATA_s; err = PSLVERR_s;
      end
      @(posedge PCLK); #1;
      PENABLE_s = 1'b1;
      cyc++;
    end
    PSEL_s = 1'b0; PENABLE_s = 1'b0;
  endtask

  // Response must last exactly one cycle.
  task automatic idle_check(input string tag);
    @(negedge PCLK);
    check(tag, {PREADY_s, PSLVERR_s, |PRDATA_s}, 3'b000);
    @(posedge PCLK); #1;
  endtask

  int            rc, sc, ec, ls;
  logic [DW-1:0] rd, wds;
  logic          er;
  logic [N-1:0]  ss;

  initial begin
    hang = '0;
    for (int i = 0; i < N; i++) begin
      waits[i] = 0;
      wcnt[i]  = 0;
    end
    PRDATA_m  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    PSLVERR_m = '0;

    // Reset held two cycles with random upstream activity.
    PRESET = 1'b1;
    PSEL_s = 1'($urandom); PENABLE_s = 1'($urandom); PWRITE_s = 1'($urandom);
    PADDR_s = $urandom; PWDATA_s = $urandom; PSTRB_s = 4'($urandom); PPROT_s = 3'($urandom);
    @(posedge PCLK); #1;
    PSEL_s = 1'b1; PENABLE_s = 1'b0; PADDR_s = $urandom;
    @(negedge PCLK);
    check("reset_c1_outputs", any_output(), 1'b0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("reset_c2_outputs", any_output(), 1'b0);
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL_s = 1'b0; PENABLE_s = 1'b0;
    @(posedge PCLK); #1;

    // Write to slave 1, zero-wait.
    xfer(32'h1000_0010, 1'b1, 32'hDEAD_BEEF, rc, rd, er, sc, ec, ls, ss, wds);
    check("wr1_sel_cycle", sc, 1);
    check("wr1_en_cycle", ec, 2);
    check("wr1_sel_only_s1", ss, 4'b0010);
    check("wr1_pwdata", wds, 32'hDEAD_BEEF);
    check("wr1_ready_cycle", rc, 3);
    check("wr1_slverr", er, 1'b0);
    idle_check("wr1_resp_one_cycle");

    // Read from slave 2 with three wait states and an error.
    waits[2] = 3; PRDATA_m[2] = 32'hCAFE_F00D; PSLVERR_m[2] = 1'b1;
    xfer(32'h2000_0000, 1'b0, 32'h0, rc, rd, er, sc, ec, ls, ss, wds);
    check("rd2_ready_cycle", rc, 6);
    check("rd2_prdata", rd, 32'hCAFE_F00D);
    check("rd2_slverr", er, 1'b1);
    check("rd2_sel_only_s2", ss, 4'b0100);
    idle_check("rd2_resp_one_cycle");
    waits[2] = 0; PSLVERR_m[2] = 1'b0;

    // Unmapped address.
    xfer(32'hF000_0000, 1'b0, 32'h0, rc, rd, er, sc, ec, ls, ss, wds);
    check("miss_no_psel", ss, 4'b0000);
    check("miss_ready_cycle", rc, 1);
    check("miss_slverr", er, 1'b1);
    check("miss_prdata", rd, 32'h0);
    idle_check("miss_resp_one_cycle");

`ifdef APB_DEMUX_TIMEOUT_EN
    // Slave 0 never answers: 8 access cycles (2..9), then DONE in cycle 10.
    hang[0] = 1'b1; PRDATA_m[0] = 32'h1234_5678;
    xfer(32'h0000_0040, 1'b0, 32'h0, rc, rd, er, sc, ec, ls, ss, wds);
    check("to_last_sel_cycle", ls, 9);
    check("to_ready_cycle", rc, 10);
    check("to_slverr", er, 1'b1);
    check("to_prdata", rd, 32'h0);
    hang[0] = 1'b0;
    // Ready on the expiring cycle wins.
    waits[0] = 7; PRDATA_m[0] = 32'hA5A5_0000;
    xfer(32'h0000_0044, 1'b0, 32'h0, rc, rd, er, sc, ec, ls, ss, wds);
    check("to_race_ready_cycle", rc, 10);
    check("to_race_slverr", er, 1'b0);
    check("to_race_prdata", rd, 32'hA5A5_0000);
`else
    // Without the timeout a long wait simply completes.
    waits[0] = 12; PRDATA_m[0] = 32'hA5A5_0000;
    xfer(32'h0000_0044, 1'b0, 32'h0, rc, rd, er, sc, ec, ls, ss, wds);
    check("long_wait_ready_cycle", rc, 15);
    check("long_wait_slverr", er, 1'b0);
    check("long_wait_prdata", rd, 32'hA5A5_0000);
`endif
    waits[0] = 0;

    // Back-to-back writes to slaves 0 and 3.
    xfer(32'h0000_0004, 1'b1, 32'h0BAD_F00D, rc, rd, er, sc, ec, ls, ss, wds);
    check("b2b_a_ready_cycle", rc, 3);
    check("b2b_a_sel", ss, 4'b0001);
    check("b2b_a_pwdata", wds, 32'h0BAD_F00D);
    xfer(32'h3000_0008, 1'b1, 32'h5555_AAAA, rc, rd, er, sc, ec, ls, ss, wds);
    check("b2b_b_ready_cycle", rc, 3);
    check("b2b_b_sel", ss, 4'b1000);
    check("b2b_b_pwdata", wds, 32'h5555_AAAA);

    // Reset pulsed during ACCESS of a third transfer.
    hang[2] = 1'b1;
    PSEL_s = 1'b1; PENABLE_s = 1'b0; PWRITE_s = 1'b0; PADDR_s = 32'h2000_0020;
    @(posedge PCLK); #1;
    PENABLE_s = 1'b1;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("mid_rst_in_access", {PSEL_m, PENABLE_m}, {4'b0100, 4'b0100});
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    check("mid_rst_outputs", any_output(), 1'b0);
    PRESET = 1'b0; PSEL_s = 1'b0; PENABLE_s = 1'b0; hang[2] = 1'b0;
    @(posedge PCLK); #1;
    PRDATA_m[2] = 32'h600D_CAFE;
    xfer(32'h2000_0020, 1'b0, 32'h0, rc, rd, er, sc, ec, ls, ss, wds);
    check("post_rst_ready_cycle", rc, 3);
    check("post_rst_prdata", rd, 32'h600D_CAFE);
    check("post_rst_slverr", er, 1'b0);
    idle_check("post_rst_resp_one_cycle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
